// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The optional FETCH_PERF_EN build adds perf counters to fetch_unit.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // Default entry layout for a 32-bit PC; fetch_unit builds its own for other XLEN.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush and occupancy output.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     wdata_i,
  input  logic                       pop_i,
  output entry_t                     rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  entry_t        mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Pops on an empty FIFO are ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generator, credit-limited memory requests,
// prefetch FIFO toward decode, redirect flush with stale-response drain. FETCH_PERF_EN adds perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // imem_req_addr holds while valid is high and ready is low. Decode takes the head on
  // instr_valid && instr_ready. Responses carry no ready and arrive in request order.

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  entry_t          fifo_wdata;
  entry_t          fifo_rdata;
  logic            credit_ok;
  logic            req_fire;

  // Buffered plus in-flight entries never exceed DEPTH, so the FIFO cannot overflow.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (redirect_valid && (outstanding_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    fifo_push      = 1'b0;
    case (state_q)
      RUN: begin
        imem_req_valid = rst && !redirect_valid && credit_ok;
        fifo_push      = imem_rsp_valid && !redirect_valid;
      end
      default: begin
        imem_req_valid = 1'b0;
        fifo_push      = 1'b0;
      end
    endcase
  end

  assign req_fire = imem_req_valid && imem_req_ready;

  always_comb begin
    outstanding_d = outstanding_q + {{(CW-1){1'b0}}, req_fire}
                                  - {{(CW-1){1'b0}}, imem_rsp_valid};
    drop_cnt_d = drop_cnt_q;
    // On redirect every response still owed belongs to the abandoned stream.
    if (redirect_valid) begin
      drop_cnt_d = outstanding_d;
    end else if ((state_q == DRAIN) && imem_rsp_valid) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (req_fire)   fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);

    rsp_pc_d = rsp_pc_q;
    if (redirect_valid)  rsp_pc_d = redirect_pc;
    else if (fifo_push)  rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign fifo_wdata = '{pc: rsp_pc_q, instr: imem_rsp_data};
  assign fifo_pop   = instr_valid && instr_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign instr_valid   = !fifo_empty;
  assign instr         = fifo_empty ? '0 : fifo_rdata.instr;
  assign instr_pc      = fifo_empty ? '0 : fifo_rdata.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fifo_push)      perf_fetch_q <= sat_inc32(perf_fetch_q);
      if (redirect_valid) perf_flush_q <= sat_inc32(perf_flush_q);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
